// File: rtl/wb_dfx_sequencer_pkg.sv
// Shared types and constants for the DFX reconfiguration sequencer.
// Holds the FSM state enum, the RESULT codes, the software register map
// (CTRL bit indices, STAT field positions) and the DFX status decode constants.
package wb_dfx_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_SIZE,
    ST_WR_TRIG,
    ST_POLL_RD,
    ST_POLL_WAIT,
    ST_FINISH
  } state_e;

  typedef enum logic [2:0] {
    RES_NONE    = 3'd0,
    RES_DONE    = 3'd1,
    RES_DFX_ERR = 3'd2,
    RES_BUS_ERR = 3'd3,
    RES_TIMEOUT = 3'd4,
    RES_ABORTED = 3'd5
  } result_e;

  // Software register word addresses
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STAT    = 2'd1;
  localparam logic [1:0] REG_BS_ADDR = 2'd2;
  localparam logic [1:0] REG_BS_SIZE = 2'd3;

  // CTRL bits (self-clearing strobes)
  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IRQ_CLR = 2;

  // STAT field positions
  localparam int STAT_BUSY       = 0;
  localparam int STAT_RESULT_LSB = 1;
  localparam int STAT_DFX_LSB    = 8;

  // DFX status decode: any bit in [6:3] is an error, [2:0] == 3'b111 is loaded
  localparam int         DFX_ERR_MSB = 6;
  localparam int         DFX_ERR_LSB = 3;
  localparam logic [2:0] DFX_LOADED  = 3'b111;

  // Byte-enable merge of a write into a 32-bit register
  function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_dfx_sequencer_master.sv
// Single-transaction pipelined Wishbone master.
// req_i (one-cycle pulse, only while idle) launches one read or write with
// we_i/adr_i/dat_i; done_o pulses in the ack/err cycle with err_o and rdata_o
// valid alongside. Owns cyc/stb: stb drops on the first non-stalled cycle,
// cyc drops on the edge that samples ack or err.
// Ports: clk, rst (sync, active high), request side, wbm_* bus side.
module wb_single_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [4:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [4:0]  wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_stall_i,
  input  logic        wbm_err_i
);

  logic        cyc_q, stb_q, we_q;
  logic [3:0]  sel_q;
  logic [4:0]  adr_q;
  logic [31:0] dat_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      sel_q <= 4'h0;
      adr_q <= 5'd0;
      dat_q <= 32'd0;
    end else if (cyc_q) begin
      if (stb_q && !wbm_stall_i) stb_q <= 1'b0;
      if (wbm_ack_i || wbm_err_i) begin
        cyc_q <= 1'b0;
        stb_q <= 1'b0;
        we_q  <= 1'b0;
        sel_q <= 4'h0;
      end
    end else if (req_i) begin
      cyc_q <= 1'b1;
      stb_q <= 1'b1;
      we_q  <= we_i;
      sel_q <= 4'hF;
      adr_q <= adr_i;
      dat_q <= dat_i;
    end
  end

  assign done_o    = cyc_q & (wbm_ack_i | wbm_err_i);
  assign err_o     = cyc_q & wbm_err_i;
  assign rdata_o   = wbm_dat_i;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: rtl/wb_dfx_sequencer.sv
// Partial-reconfiguration sequencer. Software programs BS_ADDR/BS_SIZE and
// writes START; the block writes both to the DFX controller, fires its
// software trigger, polls DFX status until loaded / error / timeout / abort
// and pulses irq_o. Result and last DFX status are visible in STAT.
// Ports: clk, rst (sync, active high); wbs_* CPU-side slave (4 words);
// wbm_* master into the DFX register slave; irq_o completion pulse.
module wb_dfx_sequencer
  import wb_dfx_sequencer_pkg::*;
#(
  parameter logic [4:0]  ADR_BS_ADDR    = 5'd2,
  parameter logic [4:0]  ADR_BS_SIZE    = 5'd3,
  parameter logic [4:0]  ADR_TRIGGER    = 5'd1,
  parameter logic [4:0]  ADR_STATUS     = 5'd0,
  parameter int unsigned POLL_GAP       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wbs_adr,
  input  logic [31:0] wbs_dat_w,
  output logic [31:0] wbs_dat_r,
  input  logic [3:0]  wbs_sel,
  input  logic        wbs_cyc,
  input  logic        wbs_stb,
  input  logic        wbs_we,
  output logic        wbs_ack,
  output logic        wbs_stall,
  output logic        wbs_err,
  output logic [4:0]  wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_stall_i,
  input  logic        wbm_err_i,
  output logic        irq_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  state_e      state_q;
  result_e     result_q;
  logic [7:0]  dfx_status_q;
  logic [31:0] bs_addr_q, bs_size_q;
  logic        abort_pend_q, irq_q;
  logic        req_q, m_we_q;
  logic [4:0]  m_adr_q;
  logic [31:0] m_dat_q;
  logic [TW-1:0] timer_q;
  logic [GW-1:0] gap_q;
  logic        ack_q;
  logic [31:0] dat_r_q, rdata_d;

  logic        m_done, m_err;
  logic [31:0] m_rdata;
  logic        unused_rdata_hi;

  // ---------------- slave decode ----------------
  logic wr, ctrl_wr, start_wr, abort_wr, irq_clr_wr, busy, abort_now, timed_out;
  assign wr         = wbs_cyc & wbs_stb & wbs_we;
  assign ctrl_wr    = wr && (wbs_adr == REG_CTRL);
  assign start_wr   = ctrl_wr & wbs_dat_w[CTRL_START];
  assign abort_wr   = ctrl_wr & wbs_dat_w[CTRL_ABORT];
  assign irq_clr_wr = ctrl_wr & wbs_dat_w[CTRL_IRQ_CLR];
  assign busy       = (state_q != ST_IDLE);
  // An ABORT written in the same cycle as a completion is honoured at once.
  assign abort_now  = abort_pend_q | abort_wr;
  assign timed_out  = (timer_q == TW'(TIMEOUT_CYCLES));

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rdata_d = 32'd0;
    unique case (wbs_adr)
      REG_STAT: begin
        rdata_d[STAT_BUSY]               = busy;
        rdata_d[STAT_RESULT_LSB +: 3]    = result_q;
        rdata_d[STAT_DFX_LSB +: 8]       = dfx_status_q;
      end
      REG_BS_ADDR: rdata_d = bs_addr_q;
      REG_BS_SIZE: rdata_d = bs_size_q;
      default:     rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      dat_r_q <= 32'd0;
    end else begin
      ack_q <= wbs_cyc & wbs_stb;
      if (wbs_cyc && wbs_stb && !wbs_we) dat_r_q <= rdata_d;
    end
  end

  assign wbs_ack   = ack_q;
  assign wbs_dat_r = dat_r_q;
  assign wbs_stall = 1'b0;
  assign wbs_err   = 1'b0;

  // ---------------- sequencer FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      result_q     <= RES_NONE;
      dfx_status_q <= 8'd0;
      bs_addr_q    <= 32'd0;
      bs_size_q    <= 32'd0;
      abort_pend_q <= 1'b0;
      irq_q        <= 1'b0;
      req_q        <= 1'b0;
      m_we_q       <= 1'b0;
      m_adr_q      <= 5'd0;
      m_dat_q      <= 32'd0;
      timer_q      <= '0;
      gap_q        <= '0;
    end else begin
      irq_q <= 1'b0;
      req_q <= 1'b0;
      // NOTE: later non-blocking assignments in this block override earlier
      // ones, so FSM result updates below take priority over IRQ_CLR.
      if (irq_clr_wr) result_q <= RES_NONE;
      if (!busy && wr && wbs_adr == REG_BS_ADDR) bs_addr_q <= apply_be(bs_addr_q, wbs_dat_w, wbs_sel);
      if (!busy && wr && wbs_adr == REG_BS_SIZE) bs_size_q <= apply_be(bs_size_q, wbs_dat_w, wbs_sel);
      if (busy && abort_wr) abort_pend_q <= 1'b1;
      if ((state_q == ST_POLL_RD || state_q == ST_POLL_WAIT) && !timed_out)
        timer_q <= timer_q + TW'(1);

      unique case (state_q)
        ST_IDLE: if (start_wr) begin
          state_q      <= ST_WR_ADDR;
          result_q     <= RES_NONE;
          abort_pend_q <= 1'b0;
          req_q        <= 1'b1;
          m_we_q       <= 1'b1;
          m_adr_q      <= ADR_BS_ADDR;
          m_dat_q      <= bs_addr_q;
        end
        ST_WR_ADDR, ST_WR_SIZE, ST_WR_TRIG: if (m_done) begin
          if (m_err) begin
            state_q <= ST_FINISH; result_q <= RES_BUS_ERR;
          end else if (abort_now) begin
            state_q <= ST_FINISH; result_q <= RES_ABORTED;
          end else if (state_q == ST_WR_ADDR) begin
            state_q <= ST_WR_SIZE; req_q <= 1'b1;
            m_adr_q <= ADR_BS_SIZE; m_dat_q <= bs_size_q;
          end else if (state_q == ST_WR_SIZE) begin
            state_q <= ST_WR_TRIG; req_q <= 1'b1;
            m_adr_q <= ADR_TRIGGER; m_dat_q <= 32'h1;
          end else begin
            state_q <= ST_POLL_RD; req_q <= 1'b1;
            m_we_q  <= 1'b0; m_adr_q <= ADR_STATUS; m_dat_q <= 32'd0;
            timer_q <= '0;
          end
        end
        ST_POLL_RD: if (m_done) begin
          if (m_err) begin
            state_q <= ST_FINISH; result_q <= RES_BUS_ERR;
          end else begin
            dfx_status_q <= m_rdata[7:0];
            if (m_rdata[DFX_ERR_MSB:DFX_ERR_LSB] != '0) begin
              state_q <= ST_FINISH; result_q <= RES_DFX_ERR;
            end else if (m_rdata[2:0] == DFX_LOADED) begin
              state_q <= ST_FINISH; result_q <= RES_DONE;
            end else if (abort_now) begin
              state_q <= ST_FINISH; result_q <= RES_ABORTED;
            end else if (timed_out) begin
              state_q <= ST_FINISH; result_q <= RES_TIMEOUT;
            end else begin
              state_q <= ST_POLL_WAIT;
              gap_q   <= GW'(POLL_GAP - 1);
            end
          end
        end
        ST_POLL_WAIT: begin
          if (abort_now) begin
            state_q <= ST_FINISH; result_q <= RES_ABORTED;
          end else if (timed_out) begin
            state_q <= ST_FINISH; result_q <= RES_TIMEOUT;
          end else if (gap_q == '0) begin
            state_q <= ST_POLL_RD; req_q <= 1'b1;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        ST_FINISH: begin
          irq_q        <= 1'b1;
          abort_pend_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign irq_o = irq_q;

  wb_single_master u_master (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_q),
    .we_i        (m_we_q),
    .adr_i       (m_adr_q),
    .dat_i       (m_dat_q),
    .done_o      (m_done),
    .err_o       (m_err),
    .rdata_o     (m_rdata),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_we_o    (wbm_we_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_stall_i (wbm_stall_i),
    .wbm_err_i   (wbm_err_i)
  );

  // Only the low status byte is architecturally visible.
  assign unused_rdata_hi = ^m_rdata[31:8];

endmodule

// File: tb/tb_wb_dfx_sequencer.sv
// Directed self-checking bench for wb_dfx_sequencer with a small DFX register
// slave model (stall / error injection, scripted status values).
module tb_wb_dfx_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wbs_adr;
  logic [31:0] wbs_dat_w, wbs_dat_r;
  logic [3:0]  wbs_sel;
  logic        wbs_cyc, wbs_stb, wbs_we, wbs_ack, wbs_stall, wbs_err;
  logic [4:0]  wbm_adr_o;
  logic [31:0] wbm_dat_o, wbm_dat_i;
  logic        wbm_we_o, wbm_stb_o, wbm_cyc_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i, wbm_stall_i, wbm_err_i, irq_o;

  always #5 clk = ~clk;

  wb_dfx_sequencer #(.POLL_GAP(16), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst),
    .wbs_adr(wbs_adr), .wbs_dat_w(wbs_dat_w), .wbs_dat_r(wbs_dat_r), .wbs_sel(wbs_sel),
    .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we),
    .wbs_ack(wbs_ack), .wbs_stall(wbs_stall), .wbs_err(wbs_err),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o), .wbm_sel_o(wbm_sel_o),
    .wbm_ack_i(wbm_ack_i), .wbm_stall_i(wbm_stall_i), .wbm_err_i(wbm_err_i),
    .irq_o(irq_o)
  );

  int checks = 0;
  int failures = 0;

  // DFX slave model state and transaction log
  int          stall_adr = -1, stall_n = 0, err_adr = -1;
  logic [7:0]  status_hold = 8'h00;
  logic [7:0]  status_fifo[$];
  int          n_tx = 0, cur = 0, idle_run = 0, stall_left = 0;
  int          cyc_no = 0, irq_cnt = 0, irq_cyc = 0, trig_ack_cyc = 0;
  logic [4:0]  adr_log[64];
  logic [31:0] dat_log[64];
  logic        we_log[64];
  int          gap_log[64], stb_log[64], cyc_log[64];
  logic        prev_cyc = 1'b0;
  logic        resp_pending = 1'b0, resp_err = 1'b0, resp_trig = 1'b0;
  logic [31:0] resp_dat = 32'd0;

  // Responder acts on the falling edge; its inputs are seen at the next rising edge.
  initial begin
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_stall_i = 1'b0; wbm_dat_i = 32'd0;
    forever begin
      @(negedge clk);
      cyc_no++;
      if (irq_o) begin irq_cnt++; irq_cyc = cyc_no; end
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
      if (resp_pending) begin
        if (resp_err) wbm_err_i = 1'b1; else wbm_ack_i = 1'b1;
        wbm_dat_i = resp_dat;
        if (resp_trig) trig_ack_cyc = cyc_no;
        resp_pending = 1'b0;
      end
      if (wbm_cyc_o && !prev_cyc) begin
        cur = n_tx;
        if (cur < 64) begin gap_log[cur] = idle_run; stb_log[cur] = 0; cyc_log[cur] = 0; end
        n_tx++;
        idle_run = 0;
        stall_left = (int'(wbm_adr_o) == stall_adr) ? stall_n : 0;
      end
      if (!wbm_cyc_o) idle_run++;
      else if (cur < 64) cyc_log[cur]++;
      if (wbm_cyc_o && wbm_stb_o) begin
        if (cur < 64) stb_log[cur]++;
        if (stall_left > 0) begin
          wbm_stall_i = 1'b1;
          stall_left--;
        end else begin
          wbm_stall_i = 1'b0;
          if (cur < 64) begin adr_log[cur] = wbm_adr_o; dat_log[cur] = wbm_dat_o; we_log[cur] = wbm_we_o; end
          resp_pending = 1'b1;
          resp_err  = (int'(wbm_adr_o) == err_adr);
          resp_trig = wbm_we_o && (wbm_adr_o == 5'd1);
          if (!wbm_we_o) resp_dat = {24'd0, (status_fifo.size() > 0) ? status_fifo.pop_front() : status_hold};
          else resp_dat = 32'd0;
        end
      end else begin
        wbm_stall_i = 1'b0;
      end
      prev_cyc = wbm_cyc_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One slave write; returns at #1 after the sampling edge with the ack level.
  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s, output logic ack);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1; wbs_adr = a; wbs_dat_w = d; wbs_sel = s;
    @(posedge clk); #1;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    ack = wbs_ack;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d, output logic ack);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = a;
    @(posedge clk); #1;
    wbs_cyc = 1'b0; wbs_stb = 1'b0;
    ack = wbs_ack; d = wbs_dat_r;
  endtask

  task automatic wait_irq(input int base, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (irq_cnt != base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_tx(input int n, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (n_tx >= n && wbm_cyc_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  logic [31:0] rd;
  logic        ak, ok;
  int          base, delta;

  initial begin
    rst = 1'b1; wbs_adr = 2'd0; wbs_dat_w = 32'd0; wbs_sel = 4'h0;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    idle(3);
    // Reset state
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_we", wbm_we_o, 0);
    check("rst_sel", wbm_sel_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_wbs_ack", wbs_ack, 0);
    check("wbs_stall_err", {wbs_stall, wbs_err}, 0);
    rst = 1'b0;
    idle(1);
    wb_read(2'd1, rd, ak);
    check("stat_after_rst_ack", ak, 1);
    check("stat_after_rst", rd, 32'h0);

    // Nominal flow
    wb_write(2'd2, 32'h0020_0000, 4'hF, ak);
    check("bs_addr_wr_ack", ak, 1);
    wb_write(2'd3, 32'h0001_2000, 4'hF, ak);
    wb_read(2'd2, rd, ak);
    check("bs_addr_rb", rd, 32'h0020_0000);
    status_fifo.push_back(8'h00); status_fifo.push_back(8'h00); status_fifo.push_back(8'h07);
    n_tx = 0; base = irq_cnt;
    wb_write(2'd0, 32'h1, 4'hF, ak);
    check("start_stb_not_yet", wbm_stb_o, 0);
    @(posedge clk); #1;
    check("start_stb_2cyc", wbm_stb_o, 1);
    check("start_sel", wbm_sel_o, 4'hF);
    wait_irq(base, 300, ok);
    check("nom_irq_seen", ok, 1);
    idle(4);
    check("nom_irq_once", irq_cnt - base, 1);
    check("nom_ntx", n_tx, 6);
    check("nom_w0", {27'd0, adr_log[0]} ^ dat_log[0], 32'h0020_0002);
    check("nom_w0_adr", adr_log[0], 5'd2);
    check("nom_w1", dat_log[1], 32'h0001_2000);
    check("nom_w1_adr", adr_log[1], 5'd3);
    check("nom_w2", {adr_log[2], dat_log[2][26:0], we_log[2]}, {5'd1, 27'h1, 1'b1});
    check("nom_reads", {we_log[3], we_log[4], we_log[5], adr_log[5]}, 8'h00);
    check("nom_b2b_gap", gap_log[1] >= 1, 1);
    check("nom_poll_gap1", gap_log[4] >= 16, 1);
    check("nom_poll_gap2", gap_log[5] >= 16, 1);
    check("nom_stb_cyc", {stb_log[0][7:0], cyc_log[0][7:0]}, 16'h0102);
    wb_read(2'd1, rd, ak);
    check("nom_stat", rd, 32'h0000_0702);

    // Byte enables and IRQ_CLR
    wb_write(2'd2, 32'hAABB_CCDD, 4'b0101, ak);
    wb_read(2'd2, rd, ak);
    check("bs_addr_sel", rd, 32'h00BB_00DD);
    wb_write(2'd0, 32'h4, 4'hF, ak);
    wb_read(2'd1, rd, ak);
    check("irq_clr_stat", rd, 32'h0000_0700);

    // DFX error
    status_fifo.push_back(8'h18);
    n_tx = 0; base = irq_cnt;
    wb_write(2'd0, 32'h1, 4'hF, ak);
    wait_irq(base, 300, ok);
    check("dfxerr_irq_seen", ok, 1);
    idle(40);
    check("dfxerr_ntx", n_tx, 4);
    wb_read(2'd1, rd, ak);
    check("dfxerr_stat", rd, 32'h0000_1804);

    // Bus error on WR_SIZE
    err_adr = 3;
    n_tx = 0; base = irq_cnt;
    wb_write(2'd0, 32'h1, 4'hF, ak);
    wait_irq(base, 300, ok);
    check("buserr_irq_seen", ok, 1);
    idle(10);
    err_adr = -1;
    check("buserr_no_trig", n_tx, 2);
    wb_read(2'd1, rd, ak);
    check("buserr_stat", rd, 32'h0000_1806);

    // Stall on the trigger write
    stall_adr = 1; stall_n = 3;
    status_fifo.push_back(8'h07);
    n_tx = 0; base = irq_cnt;
    wb_write(2'd0, 32'h1, 4'hF, ak);
    wait_irq(base, 300, ok);
    check("stall_irq_seen", ok, 1);
    check("stall_stb_cycles", stb_log[2], 4);
    check("stall_cyc_cycles", cyc_log[2], 5);
    wb_read(2'd1, rd, ak);
    check("stall_stat", rd, 32'h0000_0702);

    // Abort during a stalled trigger write; START and BS_ADDR write while busy
    stall_n = 10;
    n_tx = 0; base = irq_cnt;
    wb_write(2'd0, 32'h1, 4'hF, ak);
    wait_tx(3, 50, ok);
    check("abort_trig_started", ok, 1);
    wb_write(2'd0, 32'h1, 4'hF, ak);
    wb_write(2'd2, 32'h1234_5678, 4'hF, ak);
    wb_write(2'd0, 32'h2, 4'hF, ak);
    wait_irq(base, 300, ok);
    check("abort_irq_seen", ok, 1);
    idle(40);
    check("abort_ntx", n_tx, 3);
    check("abort_trig_completed", cyc_log[2], 12);
    check("abort_irq_once", irq_cnt - base, 1);
    wb_read(2'd1, rd, ak);
    check("abort_stat", rd, 32'h0000_070A);
    wb_read(2'd2, rd, ak);
    check("busy_bs_addr_ignored", rd, 32'h00BB_00DD);
    stall_adr = -1; stall_n = 0;

    // START together with ABORT in IDLE performs START
    status_fifo.push_back(8'h07);
    n_tx = 0; base = irq_cnt;
    wb_write(2'd0, 32'h3, 4'hF, ak);
    wait_irq(base, 300, ok);
    check("start_abort_irq", ok, 1);
    wb_read(2'd1, rd, ak);
    check("start_abort_stat", rd, 32'h0000_0702);

    // Timeout with status stuck at 0
    status_hold = 8'h00;
    n_tx = 0; base = irq_cnt;
    wb_write(2'd0, 32'h1, 4'hF, ak);
    wait_irq(base, 400, ok);
    check("timeout_irq_seen", ok, 1);
    delta = irq_cyc - trig_ack_cyc;
    check("timeout_latency_ok", (delta >= 100 && delta <= 125), 1);
    wb_read(2'd1, rd, ak);
    check("timeout_stat", rd, 32'h0000_0008);

    // Reset in the middle of a status poll
    n_tx = 0; base = irq_cnt;
    wb_write(2'd0, 32'h1, 4'hF, ak);
    wait_tx(4, 100, ok);
    check("midpoll_reached", ok, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midpoll_cyc_dropped", wbm_cyc_o, 0);
    rst = 1'b0;
    wb_read(2'd1, rd, ak);
    check("midpoll_stat", rd, 32'h0);
    wb_read(2'd2, rd, ak);
    check("midpoll_bs_addr", rd, 32'h0);
    idle(40);
    check("midpoll_no_irq", irq_cnt - base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_dfx_sequencer.md
# wb_dfx_sequencer

Sequences a partial reconfiguration on behalf of software. It owns the register port of the Wishbone DFX controller wrapper as a Wishbone master, and programs the bitstream address and size. It then fires the software trigger, polls the DFX status register until the reconfiguration completes, fails or times out, and raises an interrupt. It sits between the CPU-side Wishbone crossbar (slave port) and the DFX controller's 5-bit word-addressed register slave (master port).

## Interface
Parameters:
- ADR_BS_ADDR, 5'd2: DFX register word address for the RM bitstream address.
- ADR_BS_SIZE, 5'd3: DFX register word address for the RM bitstream size.
- ADR_TRIGGER, 5'd1: DFX software-trigger register word address.
- ADR_STATUS, 5'd0: DFX status register word address.
- POLL_GAP, 16: idle cycles between status polls (≥1).
- TIMEOUT_CYCLES, 2**24: cycles after the trigger ack before timeout is declared.

Ports:
- clk, in, 1: system clock. The block has one clock.
- rst, in, 1: synchronous, active-high reset.
- wbs_adr, in, 2: slave word address. 0 = CTRL, 1 = STAT, 2 = BS_ADDR, 3 = BS_SIZE.
- wbs_dat_w / wbs_dat_r, in/out, 32: slave write and read data.
- wbs_sel, in, 4: byte enables. These are honoured on BS_ADDR and BS_SIZE writes.
- wbs_cyc, wbs_stb, wbs_we, in, 1: slave cycle, strobe and write enable.
- wbs_ack, wbs_stall, wbs_err, out, 1: slave acknowledge, stall and error.
- wbm_adr_o, out, 5: master word address into the DFX register slave.
- wbm_dat_o, out, 32: master write data.
- wbm_dat_i, in, 32: master read data.
- wbm_we_o, wbm_stb_o, wbm_cyc_o, out, 1: master write enable, strobe and cycle.
- wbm_sel_o, out, 4: master byte enables.
- wbm_ack_i, wbm_stall_i, wbm_err_i, in, 1: master acknowledge, stall and error.
- irq_o, out, 1: one-cycle pulse on entry to DONE, FAIL, TIMEOUT or ABORTED.

## Operation
Software register map:
- CTRL (W): bit0 START, bit1 ABORT, bit2 IRQ_CLR. All are self-clearing and read as 0.
- STAT (R):
  - bit0 BUSY.
  - bits[3:1] RESULT: 0 none, 1 done, 2 dfx error, 3 bus error, 4 timeout, 5 aborted.
  - bits[15:8] last DFX status[7:0].
  - IRQ_CLR resets RESULT to 0.
- BS_ADDR, BS_SIZE (RW): byte-addressed bitstream location and size. Writes are ignored while BUSY.

FSM states: IDLE, WR_ADDR, WR_SIZE, WR_TRIG, POLL_RD, POLL_WAIT, FINISH.
- IDLE: START moves to WR_ADDR, clears RESULT and sets BUSY. START while BUSY is ignored.
- WR_ADDR: one master write of BS_ADDR to ADR_BS_ADDR.
- WR_SIZE: one master write of BS_SIZE to ADR_BS_SIZE.
- WR_TRIG: one master write of 32'h1 to ADR_TRIGGER. On its ack the timeout counter clears.
- POLL_RD: one master read of ADR_STATUS, latched into STAT[15:8]. The decode is:
  - status[6:3] ≠ 0 gives RESULT 2.
  - else status[2:0] == 3'b111 gives RESULT 1.
  - else go to POLL_WAIT.
- POLL_WAIT: wait POLL_GAP cycles, then return to POLL_RD.
- FINISH: pulse irq_o, clear BUSY, go to IDLE.

Bus and abort handling:
- A wbm_err_i on any master transaction gives RESULT 3 and goes to FINISH.
- The timeout counter saturates. Reaching TIMEOUT_CYCLES in POLL_RD or POLL_WAIT gives RESULT 4.
  - In POLL_WAIT the exit is immediate.
  - In POLL_RD the exit happens after the outstanding read completes.
- ABORT while BUSY gives RESULT 5. Any in-flight master transaction is completed (ack or err) first; it is never dropped mid-cycle. ABORT in IDLE has no effect.

## Timing
- Reset: all outputs 0 (wbm_cyc_o, wbm_stb_o, wbm_we_o, irq_o, wbs_ack). The FSM goes to IDLE, all registers clear, and wbm_sel_o = 0.
- Reset mid-transaction drops wbm_cyc_o on the next edge. Recovery of the DFX side is software's concern.
- Slave port:
  - wbs_stall is tied 0 and wbs_err is tied 0.
  - wbs_ack is asserted exactly 1 cycle after each cyc & stb.
  - wbs_dat_r is valid with the ack.
- Master port (pipelined, one transaction per cycle of the bus):
  - Raise cyc and stb together, with wbm_sel_o = 4'hF.
  - Drop stb on the first cycle with !wbm_stall_i. Hold cyc until ack or err.
  - Drop cyc the cycle after ack or err.
  - Adr, dat and we are held stable while stb is high.
- Back-to-back transactions have at least 1 idle cycle between them, with cyc low.
- START to first wbm_stb_o takes 2 cycles (slave ack cycle plus the FSM transition).
- The status decode happens in the ack cycle. irq_o fires 1 cycle after entry to FINISH.
- A simultaneous START and ABORT write in IDLE performs START only. The same write while BUSY performs ABORT.

## Structure
- Package wb_dfx_sequencer_pkg holds:
  - the FSM state enum;
  - the RESULT enum;
  - the CTRL bit indices and the STAT field positions;
  - the DFX status decode constants (error field [6:3], loaded state 3'b111).
- One sub-module, wb_single_master: performs a single Wishbone read or write given req, we, adr and dat. It returns done, err and rdata, and owns the cyc and stb handshake. The sequencer FSM issues requests to it.

## Test plan
- Nominal flow:
  - Stimulus: BS_ADDR = 32'h0020_0000, BS_SIZE = 32'h0001_2000, START. The DFX model returns status 8'h00 twice, then 8'h07.
  - Required response: master writes in order (2, 32'h0020_0000), (3, 32'h0001_2000), (1, 32'h1); 3 status reads with ≥ POLL_GAP idle cycles between them; then RESULT = 1, STAT[15:8] = 8'h07, one irq_o pulse.
- DFX error: the status read returns 8'h18 → RESULT = 2, no further master cycles.
- Stalls and errors: stall held 3 cycles on the trigger write → stb drops exactly when stall drops, cyc holds until ack. Separately, wbm_err_i on WR_SIZE → RESULT = 3, no trigger write.
- Timeout: with TIMEOUT_CYCLES = 100 and status held at 8'h00, RESULT = 4 within 100 + POLL_GAP + read latency cycles of the trigger ack.
- Abort: ABORT during a stalled WR_TRIG → the write completes, then RESULT = 5. A START during BUSY is ignored, as are BS_ADDR writes during BUSY.
- Reset mid-poll: rst asserted for 1 cycle → wbm_cyc_o = 0 next cycle, STAT reads 0, no irq_o.
